imem_responder: RTL

//  Instruction-memory responder serving the fetch stage over a valid/ready request/response interface.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/imem_rsp_fifo.sv | 66 ++++++
 rtl/imem_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and bundles.
// Holds the fetch-side instruction memory response type.
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [31:0]     instr;
    logic            fault;
  } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo: show-ahead synchronous FIFO.
// Head word is visible whenever valid; clear empties it.
module imem_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 97
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign valid   = (cnt_q != '0);
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];

  // next pointers and fill level; clear wins over push/pop
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_d = inc(wr_q);
    if (do_pop)  rd_d = inc(rd_q);
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  // pointer and level state
  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    wr_q  <= wr_d;
    cnt_q <= cnt_d;
  end

  // storage; stale words are harmless once pointers clear
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency in-order instruction ROM.
// Valid/ready request and response sides, killable by Flush.
module imem_responder
  import riscv_pkg::*;
#(
  parameter int    XLEN            = riscv_pkg::XLEN,
  parameter int    DEPTH_WORDS     = 1024,
  parameter int    LATENCY         = 2,
  parameter int    MAX_OUTSTANDING = 4,
  parameter string INIT_FILE       = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Req_Valid,
  output logic            Req_Ready,
  input  logic [XLEN-1:0] Req_Addr,
  output logic            Rsp_Valid,
  input  logic            Rsp_Ready,
  output logic [31:0]     Rsp_Instr,
  output logic [XLEN-1:0] Rsp_Addr,
  output logic            Rsp_Fault,
  input  logic            Flush
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int RW = XLEN + 33;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  if (LATENCY < 1) begin : g_bad_lat
    $error("imem_responder: LATENCY < 1");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_out
    $error("imem_responder: MAX_OUTSTANDING < 1");
  end
  if ((DEPTH_WORDS < 2) ||
      ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0))
  begin : g_bad_depth
    $error("imem_responder: DEPTH_WORDS not 2**n");
  end
  if (XLEN <= AW + 2) begin : g_bad_xlen
    $error("imem_responder: XLEN too small");
  end

  logic [31:0] rom [0:DEPTH_WORDS-1];

  logic          clr;
  logic          acc;
  logic          pop;
  logic          lk_fault;
  logic [31:0]   lk_instr;
  logic [AW-1:0] lk_idx;
  logic [RW-1:0] lk_data;
  logic          push;
  logic [RW-1:0] push_data;
  logic          f_valid;
  logic [RW-1:0] head;
  logic [CW-1:0] out_q, out_d;

  assign clr = Flush | ~rst;

  assign Req_Ready = rst & ~Flush &
                     (out_q < CW'(MAX_OUTSTANDING));
  assign acc = Req_Valid & Req_Ready;
  assign pop = Rsp_Valid & Rsp_Ready;

  assign lk_idx = Req_Addr[AW+1:2];

  // bounds/alignment check; faulting requests skip the ROM
  always_comb begin
    lk_fault = (Req_Addr[1:0] != 2'b00) |
               (Req_Addr[XLEN-1:AW+2] != '0);
    lk_instr = NOP_INSTR;
    if (!lk_fault) lk_instr = rom[lk_idx];
  end

  assign lk_data = {Req_Addr, lk_instr, lk_fault};

  if (LATENCY == 1) begin : g_direct
    assign push      = acc;
    assign push_data = lk_data;
  end else begin : g_pipe
    localparam int NS = LATENCY - 1;

    logic [NS-1:0] v_q, v_d;
    logic [RW-1:0] d_q [NS];
    logic [RW-1:0] d_d [NS];

    // shift accepted lookups toward the FIFO; kill drops all
    always_comb begin
      v_d    = '0;
      d_d    = d_q;
      v_d[0] = acc & ~clr;
      d_d[0] = lk_data;
      for (int i = 1; i < NS; i++) begin
        v_d[i] = v_q[i-1] & ~clr;
        d_d[i] = d_q[i-1];
      end
    end

    // delay stage registers
    always_ff @(posedge clk) begin
      v_q <= v_d;
      d_q <= d_d;
    end

    assign push      = v_q[NS-1];
    assign push_data = d_q[NS-1];
  end

  imem_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (RW)
  ) u_fifo (
    .clk   (clk),
    .clear (clr),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .valid (f_valid),
    .dout  (head)
  );

  // accepted-but-unpopped count; gates Req_Ready
  always_comb begin
    out_d = out_q + CW'(acc) - CW'(pop);
    if (clr) out_d = '0;
  end

  // outstanding counter state
  always_ff @(posedge clk) begin
    if (!rst) out_q <= '0;
    else      out_q <= out_d;
  end

  assign Rsp_Valid = rst & f_valid;

  // idle response reads as a harmless NOP
  always_comb begin
    Rsp_Addr  = '0;
    Rsp_Instr = NOP_INSTR;
    Rsp_Fault = 1'b0;
    if (Rsp_Valid) {Rsp_Addr, Rsp_Instr, Rsp_Fault} = head;
  end

endmodule
